// File: rtl/spi_slave_rx.sv
// Mode-0 SPI slave: oversamples sclk/cs/mosi in clk, deserialises MSB-first frames into rx_data
// and shifts tx_data out on miso. rx_valid trails the final synchronised sclk rise by SYNC_STAGES+2 clk.
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, cs_dly_q;
    logic                   sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q, mosi_q;

    state_t                 state_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [DATA_WIDTH-1:0]  tx_shift_q, rx_shift_q, rx_shift_d, rx_data_q;
    logic                   miso_q, rx_valid_q, frame_err_q, rx_done_q;

    // cs sync resets low so a cs already held low across reset never looks like a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
            sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
            sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_dly_q;
            cs_rise_q   <= cs_sync_q[SYNC_STAGES-1] & ~cs_dly_q;
            cs_fall_q   <= ~cs_sync_q[SYNC_STAGES-1] & cs_dly_q;
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
            if (rx_done_q) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall_q) begin
                        tx_shift_q <= tx_data;
                        miso_q     <= tx_data[DATA_WIDTH-1];
                        bit_cnt_q  <= '0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise_q) begin
                        state_q   <= IDLE;
                        miso_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        if (bit_cnt_q != '0)
                            frame_err_q <= 1'b1;
                    end else if (sclk_rise_q) begin
                        rx_shift_q <= rx_shift_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            rx_done_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else if (sclk_fall_q) begin
                        // A fall with the count wrapped follows the last bit: start the next reply word.
                        if (bit_cnt_q == '0) begin
                            tx_shift_q <= tx_data;
                            miso_q     <= tx_data[DATA_WIDTH-1];
                        end else begin
                            tx_shift_q <= tx_shift_q << 1;
                            miso_q     <= tx_shift_q[DATA_WIDTH-2];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == SHIFT);

endmodule
